// File: rtl/rv_ctl_mw.sv
// rv_ctl_mw: multicycle RISC-V control FSM with handshaked variable-latency memory,
// bus-error and illegal-instruction traps, and cycle/instret counters.
module rv_ctl_mw #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memrw,
    output logic             pcsourse,
    output logic             pcwrite,
    output logic             pccen,
    output logic             irwrite,
    output logic             mdrwrite,
    output logic             regwen,
    output logic [1:0]       wbsel,
    output logic [1:0]       immsel,
    output logic [1:0]       asel,
    output logic [1:0]       bsel,
    output logic [3:0]       alusel,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    localparam logic       PC_INC = 1'b0, PC_ALU = 1'b1;
    localparam logic [1:0] WB_MDR = 2'd0, WB_ALUOUT = 2'd1, WB_PC = 2'd2;
    localparam logic [1:0] IMM_L = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3;
    localparam logic [1:0] ALUA_REG = 2'd0, ALUA_PCC = 2'd1;
    localparam logic [1:0] ALUB_REG = 2'd0, ALUB_IMM = 2'd1;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001;
    localparam int WW = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_LW_MEM, S_LW_WB, S_SW_MEM,
        S_RTYPE, S_ITYPE, S_ALU_WB, S_BR, S_JAL, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              bus_err_q, illegal_q;
    logic [CNT_W-1:0]  cycle_q, instret_q;
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic              is_lw, is_sw, is_addi, is_r, is_beq, is_bne, is_jal, is_known;
    logic              mem_st, timeout, ill_trap;
    logic              unused_bits;

    assign opc         = instr[6:0];
    assign f3          = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign is_lw       = opc == 7'b0000011 && f3 == 3'b010;
    assign is_sw       = opc == 7'b0100011 && f3 == 3'b010;
    assign is_addi     = opc == 7'b0010011 && f3 == 3'b000;
    assign is_r        = opc == 7'b0110011;
    assign is_beq      = opc == 7'b1100011 && f3 == 3'b000;
    assign is_bne      = opc == 7'b1100011 && f3 == 3'b001;
    assign is_jal      = opc == 7'b1101111;
    assign is_known    = is_lw | is_sw | is_addi | is_r | is_beq | is_bne | is_jal;
    assign mem_st      = state_q == S_FETCH || state_q == S_LW_MEM || state_q == S_SW_MEM;
    // a completing handshake on the limit cycle beats the timeout
    assign timeout     = (MEM_TIMEOUT != 0) && mem_st && !mem_ready && wait_q == WW'(MEM_TIMEOUT);
    assign ill_trap    = (ILLEGAL_TRAP != 0) && state_q == S_DECODE && !is_known;
    assign wait_d      = state_d != state_q ? '0 : (mem_st && !mem_ready) ? wait_q + WW'(1) : wait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (timeout) bus_err_q <= 1'b1;
            if (ill_trap) illegal_q <= 1'b1;
            if (state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
            if (state_d == S_FETCH && state_q != S_FETCH) instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
            S_DECODE:   state_d = (is_lw || is_sw) ? S_MEM_ADDR : is_addi ? S_ITYPE : is_r ? S_RTYPE :
                                  (is_beq || is_bne) ? S_BR : is_jal ? S_JAL :
                                  (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
            S_MEM_ADDR: state_d = is_sw ? S_SW_MEM : S_LW_MEM;
            S_LW_MEM:   state_d = mem_ready ? S_LW_WB : timeout ? S_TRAP : S_LW_MEM;
            S_SW_MEM:   state_d = mem_ready ? S_FETCH : timeout ? S_TRAP : S_SW_MEM;
            S_RTYPE, S_ITYPE:                  state_d = S_ALU_WB;
            S_LW_WB, S_ALU_WB, S_BR, S_JAL:    state_d = S_FETCH;
            default:    state_d = state_q;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        memrw    = 1'b0;
        pcsourse = PC_INC;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        mdrwrite = 1'b0;
        regwen   = 1'b0;
        wbsel    = WB_PC;
        immsel   = IMM_B;
        asel     = ALUA_REG;
        bsel     = ALUB_REG;
        alusel   = ALU_ADD;
        if (!rst) begin
            case (state_q)
                S_FETCH:    begin mem_req = 1'b1; pcwrite = mem_ready; pccen = mem_ready; irwrite = mem_ready; end
                S_DECODE:   begin asel = ALUA_PCC; bsel = ALUB_IMM; end
                S_MEM_ADDR: begin bsel = ALUB_IMM; immsel = is_sw ? IMM_S : IMM_L; end
                S_LW_MEM:   begin mem_req = 1'b1; mdrwrite = mem_ready; end
                S_LW_WB:    begin wbsel = WB_MDR; regwen = 1'b1; end
                S_SW_MEM:   begin mem_req = 1'b1; memrw = 1'b1; end
                S_RTYPE:    alusel = {instr[14:12], instr[30]};
                S_ITYPE:    begin bsel = ALUB_IMM; immsel = IMM_L; end
                S_ALU_WB:   begin wbsel = WB_ALUOUT; regwen = 1'b1; end
                S_BR:       begin alusel = ALU_SUB; pcsourse = PC_ALU; pcwrite = is_bne ? !zero : zero; end
                S_JAL:      begin immsel = IMM_J; asel = ALUA_PCC; bsel = ALUB_IMM; pcsourse = PC_ALU; pcwrite = 1'b1; regwen = 1'b1; end
                default:    ;
            endcase
        end
    end

    assign halted      = state_q == S_TRAP;
    assign bus_err     = bus_err_q;
    assign illegal     = illegal_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
endmodule

// File: tb/tb_rv_ctl_mw.sv
// tb_rv_ctl_mw: two controllers (illegal opcode traps / acts as NOP) driven in lockstep
// and compared every cycle against an instruction-level sequence model.
module tb_rv_ctl_mw;
    localparam int TO = 4;
    localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_R = 4, K_BEQ = 5, K_BNE = 6, K_JAL = 7;
    localparam int B_MREQ = 22, B_MW = 21, B_PW = 19, B_MD = 16, B_RW = 15, B_HLT = 2, B_BE = 1, B_IL = 0;
    localparam logic [31:0] I_ADDI = 32'h00500093, I_LW = 32'h00002103, I_SW = 32'h00202023;
    localparam logic [31:0] I_BEQ = 32'h00000063, I_BNE = 32'h00001063, I_JAL = 32'h0000006F, I_BAD = 32'h0000007F;

    logic        clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [22:0] dout [2];
    logic [3:0]  dcyc [2], dret [2];
    int pass_n = 0, total_n = 0;
    int step [2], wt [2], kind [2], cyc [2], ret [2];
    bit trapped [2], be [2], il [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : d
        logic mq, mw, ps, pw, pc, iw, md, rw, ht, bo, io;
        logic [1:0] wb, im, a, b;
        logic [3:0] al;
        rv_ctl_mw #(.MEM_TIMEOUT(TO), .CNT_W(4), .ILLEGAL_TRAP(g == 0 ? 1 : 0)) u (
            .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
            .mem_req(mq), .memrw(mw), .pcsourse(ps), .pcwrite(pw), .pccen(pc), .irwrite(iw),
            .mdrwrite(md), .regwen(rw), .wbsel(wb), .immsel(im), .asel(a), .bsel(b), .alusel(al),
            .halted(ht), .bus_err(bo), .illegal(io), .cycle_cnt(dcyc[g]), .instret_cnt(dret[g]));
        assign dout[g] = {mq, mw, ps, pw, pc, iw, md, rw, wb, im, a, b, al, ht, bo, io};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else pass_n++;
    endtask

    function automatic int classify(input logic [31:0] i);
        logic [2:0] f = i[14:12];
        case (i[6:0])
            7'b0000011: return f == 3'b010 ? K_LW : K_ILL;
            7'b0100011: return f == 3'b010 ? K_SW : K_ILL;
            7'b0010011: return f == 3'b000 ? K_ADDI : K_ILL;
            7'b0110011: return K_R;
            7'b1100011: return f == 3'b000 ? K_BEQ : f == 3'b001 ? K_BNE : K_ILL;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    // Expected outputs from the micro-step of the current instruction: 0 fetch, 1 decode, 2.. execute.
    function automatic logic [22:0] exp_out(input int m, input logic [31:0] ins, input logic z, input logic r, input logic rs);
        logic mq = 0, mw = 0, ps = 0, pw = 0, pc = 0, iw = 0, md = 0, rw = 0;
        logic [1:0] wb = 2, im = 2, a = 0, b = 0;
        logic [3:0] al = 0;
        int k = kind[m];
        if (!rs && !trapped[m]) begin
            if (step[m] == 0) begin mq = 1; pw = r; pc = r; iw = r; end
            else if (step[m] == 1) begin a = 1; b = 1; end
            else if (k == K_LW || k == K_SW) begin
                if (step[m] == 2) begin b = 1; im = (k == K_SW) ? 2'd1 : 2'd0; end
                else if (step[m] == 3) begin mq = 1; mw = (k == K_SW); md = (k == K_LW) && r; end
                else begin wb = 0; rw = 1; end
            end else if (k == K_ADDI || k == K_R) begin
                if (step[m] == 3) begin wb = 1; rw = 1; end
                else if (k == K_ADDI) begin b = 1; im = 0; end
                else al = {ins[14:12], ins[30]};
            end else if (k == K_BEQ || k == K_BNE) begin
                al = 4'b0001; ps = 1; pw = (k == K_BEQ) ? z : !z;
            end else begin
                im = 3; a = 1; b = 1; ps = 1; pw = 1; rw = 1;
            end
        end
        return {mq, mw, ps, pw, pc, iw, md, rw, wb, im, a, b, al, trapped[m], be[m], il[m]};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            step[m] = 0; wt[m] = 0; kind[m] = K_ILL; cyc[m] = 0; ret[m] = 0;
            trapped[m] = 0; be[m] = 0; il[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input logic [31:0] ins, input logic r);
        int ns = step[m];
        bit done = 0, waiting = 0;
        if (trapped[m]) return;
        cyc[m] = (cyc[m] + 1) % 16;
        case (step[m])
            0: if (r) ns = 1; else waiting = 1;
            1: begin
                kind[m] = classify(ins);
                if (kind[m] != K_ILL) ns = 2;
                else if (m == 0) begin trapped[m] = 1; il[m] = 1; end
                else done = 1;
            end
            2: if (kind[m] inside {K_LW, K_SW, K_ADDI, K_R}) ns = 3; else done = 1;
            3: if (kind[m] == K_LW) begin if (r) ns = 4; else waiting = 1; end
               else if (kind[m] == K_SW) begin if (r) done = 1; else waiting = 1; end
               else done = 1;
            default: done = 1;
        endcase
        if (waiting) begin
            if (wt[m] == TO) begin trapped[m] = 1; be[m] = 1; end
            else wt[m]++;
        end
        if (done) begin ns = 0; ret[m] = (ret[m] + 1) % 16; end
        if (ns != step[m]) wt[m] = 0;
        step[m] = ns;
    endtask

    task automatic compare(input logic rs);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("outs_dut%0d", m), 32'(dout[m]), 32'(exp_out(m, instr, zero, mem_ready, rs)));
            chk($sformatf("cnts_dut%0d", m), 32'({dcyc[m], dret[m]}), 32'({cyc[m][3:0], ret[m][3:0]}));
        end
    endtask

    task automatic cyc_t(input logic [31:0] ins, input logic z, input logic r);
        @(negedge clk);
        rst = 1'b0; instr = ins; zero = z; mem_ready = r;
        #1;
        compare(1'b0);
        for (int m = 0; m < 2; m++) model_step(m, ins, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        model_reset();
        #1;
        compare(1'b1);
    endtask

    function automatic bit at_fetch();
        for (int m = 0; m < 2; m++) if (!trapped[m] && step[m] != 0) return 0;
        return 1;
    endfunction

    initial begin
        logic [31:0] ins;
        bit stall, was_f, f;
        do_reset();
        chk("reset_outputs", 32'(dout[0]), 32'h00005000);
        // ADDI with zero-wait memory
        cyc_t(I_ADDI, 0, 1); cyc_t(I_ADDI, 0, 1); cyc_t(I_ADDI, 0, 1);
        cyc_t(I_ADDI, 0, 1);
        chk("addi_regwen_c4", 32'(dout[0][B_RW]), 1);
        cyc_t(I_ADDI, 0, 0);
        chk("addi_instret_c5", 32'(dret[0]), 1);
        // LW with three stall cycles
        do_reset();
        cyc_t(I_LW, 0, 1); cyc_t(I_LW, 0, 1); cyc_t(I_LW, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc_t(I_LW, 0, 0);
            chk("lw_mdr_stall", 32'(dout[0][B_MD]), 0);
        end
        cyc_t(I_LW, 0, 1);
        chk("lw_mdr_ready", 32'(dout[0][B_MD]), 1);
        cyc_t(I_LW, 0, 1); cyc_t(I_LW, 0, 0);
        chk("lw_no_buserr", 32'(dout[0][B_BE]), 0);
        // branches
        for (int i = 0; i < 4; i++) begin
            ins = i[1] ? I_BEQ : I_BNE;
            cyc_t(ins, 0, 1); cyc_t(ins, 0, 1); cyc_t(ins, i[0], 1);
            chk($sformatf("br_pcwrite_%0d", i), 32'(dout[0][B_PW]), 32'(i[1] ? i[0] : !i[0]));
        end
        // fetch timeout
        do_reset();
        for (int i = 0; i < 5; i++) cyc_t(I_ADDI, 0, 0);
        cyc_t(I_ADDI, 0, 0);
        chk("to_halted", 32'(dout[0][B_HLT]), 1);
        chk("to_buserr", 32'(dout[1][B_BE]), 1);
        cyc_t(I_ADDI, 0, 1); cyc_t(I_ADDI, 0, 1);
        chk("to_cycle_frozen", 32'(dcyc[0]), 5);
        // illegal opcode: trap vs NOP
        do_reset();
        cyc_t(I_BAD, 0, 1); cyc_t(I_BAD, 0, 1); cyc_t(I_ADDI, 0, 0);
        chk("ill_trap_flags", 32'({dout[0][B_HLT], dout[0][B_IL]}), 3);
        chk("ill_nop_instret", 32'(dret[1]), 1);
        chk("ill_nop_halted", 32'(dout[1][B_HLT]), 0);
        // instret wrap on a 4-bit counter
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc_t(I_JAL, 0, 1);
            if (i == 15) chk("jal_instret_15", 32'(dret[0]), 15);
            cyc_t(I_JAL, 0, 1); cyc_t(I_JAL, 0, 1);
        end
        cyc_t(I_JAL, 0, 0);
        chk("jal_instret_wrap", 32'(dret[0]), 0);
        // reset in the middle of a store
        do_reset();
        cyc_t(I_SW, 0, 1); cyc_t(I_SW, 0, 1); cyc_t(I_SW, 0, 0);
        cyc_t(I_SW, 0, 0);
        chk("sw_req_active", 32'({dout[0][B_MREQ], dout[0][B_MW]}), 3);
        do_reset();
        chk("sw_rst_req_drop", 32'(dout[0][B_MREQ]), 0);
        // randomized instruction stream
        ins = I_ADDI; stall = 0; was_f = 0;
        for (int c = 0; c < 4000; c++) begin
            if (trapped[0] && trapped[1]) begin do_reset(); was_f = 0; continue; end
            f = at_fetch();
            if (f && !was_f) begin
                ins = $urandom;
                case ($urandom_range(0, 8))
                    0: begin ins[6:0] = 7'b0000011; ins[14:12] = 3'b010; end
                    1: begin ins[6:0] = 7'b0100011; ins[14:12] = 3'b010; end
                    2: begin ins[6:0] = 7'b0010011; ins[14:12] = 3'b000; end
                    3: ins[6:0] = 7'b0110011;
                    4: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b000; end
                    5: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b001; end
                    6: ins[6:0] = 7'b1101111;
                    7: ;
                    default: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'($urandom_range(2, 7)); end
                endcase
                stall = ($urandom_range(0, 19) == 0);
            end
            was_f = f;
            cyc_t(ins, 1'($urandom_range(0, 1)), stall ? 1'b0 : ($urandom_range(0, 9) < 7));
        end
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
